// File: rtl/dac_dual_tx_pkg.sv
// Shared sample definitions for the dual DAC transmit path and the matching AD capture path.
// A pair always packs as {ch1, ch2}, with ch1 in the upper half.
package dac_dual_tx_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(12'h800);

  typedef struct packed {
    logic [DATA_W-1:0] ch1;
    logic [DATA_W-1:0] ch2;
  } pair_t;

  function automatic pair_t pack_pair(input logic [DATA_W-1:0] ch1,
                                      input logic [DATA_W-1:0] ch2);
    pair_t p;
    p.ch1 = ch1;
    p.ch2 = ch2;
    return p;
  endfunction

endpackage

// File: rtl/dac_dual_tx_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and registered full/empty/level.
// The head entry is read combinationally so a pop and its data land on the same edge.
module dac_dual_tx_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow regardless of what the caller does.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dac_dual_tx.sv
// Dual-channel DAC transmitter: buffers sample pairs and presents them to both DAC
// buses at a fixed update rate, with a registered latch clock per channel.
module dac_dual_tx
  import dac_dual_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RATE_DIV   = 50
) (
  input  logic                         clk50m,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_ch1,
  input  logic [DATA_W-1:0]            s_ch2,
  output logic [DATA_W-1:0]            da1_out,
  output logic                         da1_clk,
  output logic [DATA_W-1:0]            da2_out,
  output logic                         da2_clk,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  underrun_cnt
);

  localparam int unsigned CNT_W = $clog2(RATE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(RATE_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_c;
  logic             push_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PAIR_W-1:0] fifo_head;
  pair_t            head;
  pair_t            wr_pair;

  assign wr_pair = pack_pair(s_ch1, s_ch2);
  assign head    = fifo_head;

  // s_ready comes straight from the registered full flag, never from this cycle's pop.
  assign s_ready = ~fifo_full;
  assign push_c  = s_valid & ~fifo_full;
  assign tick_c  = enable & (cnt == CNT_LAST);
  assign pop_c   = tick_c & ~fifo_empty;

  always_comb begin
    cnt_nxt = cnt;
    if (!enable)          cnt_nxt = '0;
    else if (tick_c)      cnt_nxt = '0;
    else                  cnt_nxt = cnt + CNT_W'(1);
  end

  dac_dual_tx_sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk50m),
    .reset_n (reset_n),
    .push    (push_c),
    .wdata   (wr_pair),
    .pop     (pop_c),
    .rdata_c (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Every tick pulses the latch clocks low; an empty tick re-latches the held code.
  always_ff @(posedge clk50m) begin
    if (!reset_n) begin
      cnt          <= '0;
      da1_out      <= MIDSCALE;
      da2_out      <= MIDSCALE;
      da1_clk      <= 1'b1;
      da2_clk      <= 1'b1;
      underrun_cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (tick_c) begin
        da1_clk <= 1'b0;
        da2_clk <= 1'b0;
        if (!fifo_empty) begin
          da1_out <= head.ch1;
          da2_out <= head.ch2;
        end else if (underrun_cnt != 16'hFFFF) begin
          underrun_cnt <= underrun_cnt + 16'd1;
        end
      end else if (!enable || (cnt_nxt == CNT_HALF)) begin
        da1_clk <= 1'b1;
        da2_clk <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_dual_tx.sv
// Directed bench for dac_dual_tx with RATE_DIV = 4 and a 16-entry FIFO.
module tb_dac_dual_tx;
  import dac_dual_tx_pkg::*;

  logic              clk50m = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_ch1;
  logic [DATA_W-1:0] s_ch2;
  logic [DATA_W-1:0] da1_out;
  logic              da1_clk;
  logic [DATA_W-1:0] da2_out;
  logic              da2_clk;
  logic [4:0]        fifo_level;
  logic [15:0]       underrun_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp1 [17];
  logic [DATA_W-1:0] exp2 [17];

  dac_dual_tx #(
    .FIFO_DEPTH (16),
    .RATE_DIV   (4)
  ) dut (
    .clk50m       (clk50m),
    .reset_n      (reset_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_ch1        (s_ch1),
    .s_ch2        (s_ch2),
    .da1_out      (da1_out),
    .da1_clk      (da1_clk),
    .da2_out      (da2_out),
    .da2_clk      (da2_clk),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk50m = ~clk50m;

  task automatic step();
    @(posedge clk50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [DATA_W-1:0] e1,
                           input logic [DATA_W-1:0] e2);
    check({tag, ".da1"}, 32'(da1_out), 32'(e1));
    check({tag, ".da2"}, 32'(da2_out), 32'(e2));
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] c1, input logic [DATA_W-1:0] c2);
    s_valid = 1'b1;
    s_ch1   = c1;
    s_ch2   = c2;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_ch1   = '0;
    s_ch2   = '0;
    step();
    step();

    // Reset state
    check_out("reset", 12'h800, 12'h800);
    check("reset.da1_clk", 32'(da1_clk), 32'd1);
    check("reset.da2_clk", 32'(da2_clk), 32'd1);
    check("reset.s_ready", 32'(s_ready), 32'd1);
    check("reset.level", 32'(fifo_level), 32'd0);
    check("reset.underrun", 32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;

    // Stream three pairs
    push_pair(12'h000, 12'hFFF);
    push_pair(12'h123, 12'h456);
    push_pair(12'h7FF, 12'h800);
    check("stream.level3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    repeat (3) step();
    check_out("stream.pre", 12'h800, 12'h800);
    check("stream.pre_clk", 32'(da1_clk), 32'd1);
    step();
    check_out("stream.p0", 12'h000, 12'hFFF);
    check("stream.p0_clk1", 32'(da1_clk), 32'd0);
    check("stream.p0_clk2", 32'(da2_clk), 32'd0);
    check("stream.p0_level", 32'(fifo_level), 32'd2);
    step();
    check("stream.clk_low1", 32'(da1_clk), 32'd0);
    step();
    check("stream.clk_high1", 32'(da1_clk), 32'd1);
    check("stream.clk_high2", 32'(da2_clk), 32'd1);
    repeat (2) step();
    check_out("stream.p1", 12'h123, 12'h456);
    check("stream.p1_clk", 32'(da2_clk), 32'd0);
    repeat (4) step();
    check_out("stream.p2", 12'h7FF, 12'h800);
    check("stream.p2_level", 32'(fifo_level), 32'd0);
    check("stream.p2_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: hold last pair, count empty ticks, keep pulsing
    repeat (4) step();
    check_out("under.t1", 12'h7FF, 12'h800);
    check("under.t1_cnt", 32'(underrun_cnt), 32'd1);
    check("under.t1_clk", 32'(da1_clk), 32'd0);
    repeat (2) step();
    check("under.t1_clkhi", 32'(da1_clk), 32'd1);
    repeat (2) step();
    check("under.t2_cnt", 32'(underrun_cnt), 32'd2);
    check("under.t2_clk", 32'(da2_clk), 32'd0);
    check_out("under.t2", 12'h7FF, 12'h800);
    enable = 1'b0;
    step();
    check("disable.clk", 32'(da1_clk), 32'd1);

    // Full: 16 pairs fill the FIFO, the 17th waits for the first pop
    for (int i = 0; i < 17; i++) begin
      exp1[i] = 12'(12'h100 + i * 7);
      exp2[i] = 12'(12'hE00 - i * 3);
    end
    for (int i = 0; i < 16; i++) push_pair(exp1[i], exp2[i]);
    check("full.level", 32'(fifo_level), 32'd16);
    check("full.s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_ch1   = exp1[16];
    s_ch2   = exp2[16];
    repeat (2) step();
    check("full.held_level", 32'(fifo_level), 32'd16);
    check("full.held_ready", 32'(s_ready), 32'd0);
    check_out("full.frozen", 12'h7FF, 12'h800);
    enable = 1'b1;
    repeat (4) step();
    check_out("full.d0", exp1[0], exp2[0]);
    check("full.d0_level", 32'(fifo_level), 32'd15);
    check("full.d0_ready", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    check("full.p17_level", 32'(fifo_level), 32'd16);
    for (int k = 1; k < 17; k++) begin
      repeat ((k == 1) ? 3 : 4) step();
      check_out($sformatf("full.d%0d", k), exp1[k], exp2[k]);
    end
    check("full.drained", 32'(fifo_level), 32'd0);
    check("full.no_underrun", 32'(underrun_cnt), 32'd2);

    // Concurrent push and pop at level 1
    push_pair(12'hA5A, 12'h5A5);
    check("conc.level1", 32'(fifo_level), 32'd1);
    repeat (2) step();
    s_valid = 1'b1;
    s_ch1   = 12'h3C3;
    s_ch2   = 12'hC3C;
    step();
    s_valid = 1'b0;
    check_out("conc.old_head", 12'hA5A, 12'h5A5);
    check("conc.level_same", 32'(fifo_level), 32'd1);
    repeat (4) step();
    check_out("conc.new_pair", 12'h3C3, 12'hC3C);
    check("conc.level0", 32'(fifo_level), 32'd0);

    // Mid-stream reset discards queued pairs
    enable = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push_pair(12'(12'h900 + i), 12'(12'h300 + i));
    check("mreset.queued", 32'(fifo_level), 32'd5);
    check("mreset.underrun_pre", 32'(underrun_cnt), 32'd2);
    enable  = 1'b1;
    reset_n = 1'b0;
    step();
    check_out("mreset.mid", 12'h800, 12'h800);
    check("mreset.level", 32'(fifo_level), 32'd0);
    check("mreset.underrun", 32'(underrun_cnt), 32'd0);
    check("mreset.clk", 32'(da1_clk), 32'd1);
    check("mreset.s_ready", 32'(s_ready), 32'd1);
    reset_n = 1'b1;
    repeat (4) step();
    check_out("mreset.t1", 12'h800, 12'h800);
    check("mreset.t1_underrun", 32'(underrun_cnt), 32'd1);
    check("mreset.t1_clk", 32'(da2_clk), 32'd0);
    repeat (4) step();
    check_out("mreset.t2", 12'h800, 12'h800);
    check("mreset.t2_underrun", 32'(underrun_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
